// File: rtl/doublesync.sv
// Multi-stage flip-flop synchroniser for quasi-static signals entering the clk domain.
// Each bit is synchronised independently; rise/fall pulses are decoded from the final stage.
module doublesync #(
  parameter int unsigned           WIDTH       = 1,
  parameter int unsigned           STAGES      = 2,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] indata,
  output logic [WIDTH-1:0] outdata,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (WIDTH < 1 || WIDTH > 256 || STAGES < 2 || STAGES > 4) begin : g_param_check
    $error("doublesync: WIDTH must be 1..256 and STAGES must be 2..4");
  end

  // Keep the chain as discrete, adjacent flops: no retiming, merging or SRL inference.
  (* ASYNC_REG = "TRUE", preserve, altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED" *)
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] prev_q;

  always_comb begin
    sync_d[0] = indata;
    for (int unsigned k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VALUE;
      end
      prev_q <= RESET_VALUE;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[STAGES-1];
    end
  end

  // prev_q tracks outdata one cycle late, so equal values after reset give no pulse.
  assign outdata = sync_q[STAGES-1];
  assign rise    = sync_q[STAGES-1] & ~prev_q;
  assign fall    = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: tb/tb_doublesync.sv
// Scoreboard bench for doublesync: four configurations share one stimulus stream and are
// checked against a history-based model of "output = input sampled STAGES edges ago".
`timescale 1ns/1ps
module tb_doublesync;

  localparam int NDUT = 4;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] ris;
    logic [7:0] fal;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;

  logic       out_a, rise_a, fall_a;
  logic [7:0] out_b, rise_b, fall_b;
  logic [7:0] out_c, rise_c, fall_c;
  logic [7:0] out_d, rise_d, fall_d;

  int unsigned stg [NDUT] = '{2, 2, 3, 4};
  logic [7:0]  rvs [NDUT] = '{8'h00, 8'h00, 8'hA5, 8'h3C};
  logic [7:0]  wm  [NDUT] = '{8'h01, 8'hFF, 8'hFF, 8'hFF};

  logic hist_rst [$];
  logic [7:0] hist_dat [$];
  exp_t sb [NDUT][$];

  int errors = 0;
  int checks = 0;

  always #41.667 clk = ~clk;

  doublesync u_a (
    .clk(clk), .reset(rst), .indata(din[0]),
    .outdata(out_a), .rise(rise_a), .fall(fall_a)
  );

  doublesync #(.WIDTH(8), .STAGES(2), .RESET_VALUE(8'h00)) u_b (
    .clk(clk), .reset(rst), .indata(din),
    .outdata(out_b), .rise(rise_b), .fall(fall_b)
  );

  doublesync #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_c (
    .clk(clk), .reset(rst), .indata(din),
    .outdata(out_c), .rise(rise_c), .fall(fall_c)
  );

  doublesync #(.WIDTH(8), .STAGES(4), .RESET_VALUE(8'h3C)) u_d (
    .clk(clk), .reset(rst), .indata(din),
    .outdata(out_d), .rise(rise_d), .fall(fall_d)
  );

  // Output after edge m: RESET_VALUE if reset was sampled on any of the last s edges,
  // otherwise the input sampled s-1 edges before edge m.
  function automatic logic [7:0] model_out(int m, int s, logic [7:0] rv);
    for (int j = m - s + 1; j <= m; j++) begin
      if (j >= 0 && hist_rst[j]) return rv;
    end
    if (m - s + 1 < 0) return rv;
    return hist_dat[m - s + 1];
  endfunction

  always @(posedge clk) begin
    int   m;
    logic [7:0] o, p;
    exp_t e;
    hist_rst.push_back(rst);
    hist_dat.push_back(din);
    m = hist_rst.size() - 1;
    for (int k = 0; k < NDUT; k++) begin
      o = model_out(m, int'(stg[k]), rvs[k]);
      if (hist_rst[m] || m == 0) p = rvs[k];
      else p = model_out(m - 1, int'(stg[k]), rvs[k]);
      e.out = o & wm[k];
      e.ris = o & ~p & wm[k];
      e.fal = ~o & p & wm[k];
      sb[k].push_back(e);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] ao [NDUT];
    logic [7:0] ar [NDUT];
    logic [7:0] af [NDUT];
    exp_t e;
    ao[0] = {7'b0, out_a}; ar[0] = {7'b0, rise_a}; af[0] = {7'b0, fall_a};
    ao[1] = out_b;         ar[1] = rise_b;         af[1] = fall_b;
    ao[2] = out_c;         ar[2] = rise_c;         af[2] = fall_c;
    ao[3] = out_d;         ar[3] = rise_d;         af[3] = fall_d;
    for (int k = 0; k < NDUT; k++) begin
      if (sb[k].size() > 0) begin
        e = sb[k].pop_front();
        chk($sformatf("dut%0d.outdata", k), ao[k], e.out);
        chk($sformatf("dut%0d.rise", k), ar[k], e.ris);
        chk($sformatf("dut%0d.fall", k), af[k], e.fal);
      end
    end
  end

  // Values take effect for the next n rising edges.
  task automatic apply(input logic r, input logic [7:0] d, input int n);
    rst = r;
    din = d;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] t;
    apply(1'b1, 8'hFF, 3);
    apply(1'b0, 8'hFF, 6);
    apply(1'b0, 8'b1111_0001, 6);
    apply(1'b0, 8'h00, 6);
    apply(1'b0, 8'h01, 6);
    apply(1'b0, 8'h00, 6);
    t = 8'h55;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, t, 1);
      t = ~t;
    end
    apply(1'b0, 8'h5A, 6);
    apply(1'b1, 8'hC3, 2);
    apply(1'b0, 8'hC3, 6);
    for (int i = 0; i < 200; i++) begin
      apply($urandom_range(0, 19) == 0, 8'($urandom), int'($urandom_range(1, 4)));
    end
    apply(1'b0, 8'h96, 6);
    @(negedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("dut%0d.scoreboard_drained", k), 8'(sb[k].size()), 8'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/doublesync.md
Name: doublesync

Overview:
- Parameterisable multi-stage flip-flop synchroniser that brings signals from a foreign clock domain into the local clock domain.
- Typical use: the 12 MHz audio-domain logic sampling 50 MHz-domain control and data, or the reverse.
- Each bit is synchronised independently. A multi-bit bus is only coherent when the source holds it stable for at least STAGES+1 destination clocks (quasi-static data).
- Optional single-cycle rise/fall pulse outputs on the synchronised value remove the need for separate edge detectors downstream.

Parameters:
- WIDTH, default 1: number of independent bits synchronised; legal range 1 to 256.
- STAGES, default 2: number of synchronising flip-flop stages; legal range 2 to 4. Elaboration fails if out of range.
- RESET_VALUE, default 0 (WIDTH bits, all zero): value loaded into every stage on reset.

Ports:
- clk  input  1  destination-domain clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- indata  input  WIDTH  asynchronous input from the foreign domain.
- outdata  output  WIDTH  synchronised value; output of the final stage.
- rise  output  WIDTH  per-bit one-cycle pulse: outdata went 0->1 on this edge.
- fall  output  WIDTH  per-bit one-cycle pulse: outdata went 1->0 on this edge.

Behaviour:
- Internal shift chain per bit: stage[0] <= indata, stage[k] <= stage[k-1], outdata = stage[STAGES-1].
- Also registered: prev <= outdata.
- rise = outdata & ~prev, fall = ~outdata & prev. These are combinational from registered state, so they are glitch-free and aligned with outdata.
- Reset: on a rising clk edge with reset=1, every stage and prev load RESET_VALUE.
  - outdata = RESET_VALUE on the edge after reset asserts.
  - rise = fall = 0 while reset is held.
  - Reset has priority over data capture.
- Reset deassertion: the chain resumes shifting on the next edge. No spurious rise/fall is generated, because prev equals outdata after reset.
- Latency: a change on indata that is stable before rising edge N appears on outdata after edge N+STAGES-1, i.e. STAGES rising edges. Default is 2 edges.
- rise/fall pulse on the same cycle outdata changes and last exactly one clk cycle.
- Input held constant: outdata constant, no pulses.
- Input pulse shorter than one clk period may be lost. This is legal; no pulse stretching.
- Input toggling every clk cycle: outdata reproduces the toggling delayed by STAGES; rise and fall alternate every cycle.
- Before the first reset with no reset applied: outputs are X in simulation until STAGES edges have captured a known indata. After that, outdata must equal the input sampled STAGES edges earlier.
- No combinational path from indata to any output.
- Synchroniser registers carry a synthesis attribute marking them as synchroniser chain (ASYNC_REG / altera preserve). They must not be retimed, merged or converted to shift-register RAM.
- Bits are never cross-coupled; each bit's behaviour is independent of the others.

Test Plan:
- WIDTH=1, STAGES=2, clk period 83.33 ns, reset=0. Drive indata=1 before an edge. Required: outdata=1 after exactly 2 rising edges (still previous/X after 1 edge); rise=1 for one cycle at that point, fall=0.
- WIDTH=8. Drive indata=8'b11110001 and hold. Required: outdata=8'b11110001 after 2 edges. rise=8'b11110001 for one cycle, then 0.
- Reset: hold reset=1 with indata=8'hFF for 3 edges. Required: outdata=RESET_VALUE (8'h00), rise=fall=0. Release reset: outdata=8'hFF 2 edges later with a single rise pulse 8'hFF.
- Falling edge: settle indata=1, drive 0. Required: outdata=0 after 2 edges, fall=1 for exactly one cycle.
- Toggle indata every clk edge for 10 cycles. Required: outdata equals indata delayed 2 edges; rise and fall alternate each cycle.
- STAGES=3, RESET_VALUE=8'hA5. Required: after reset outdata=8'hA5; a new input appears after exactly 3 edges.
